// File: rtl/seq_mult_hs.sv
// Parametrised radix-2^BPC shift-and-add multiplier with valid/ready handshakes.
// Optional early termination when the remaining multiplier is zero: SEQ_MULT_EARLY_TERM_EN.
module seq_mult_hs #(
  parameter int WIDTH = 8,
  parameter int BPC   = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               ovf,
  output logic               busy
);

  localparam int N  = WIDTH / BPC;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (WIDTH < 2 || BPC < 1 || (WIDTH % BPC) != 0) begin : g_param_err
    $error("seq_mult_hs: WIDTH must be >= 2 and a multiple of BPC");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t             state_r;
  logic [WIDTH-1:0]   mcand_r;
  logic [WIDTH-1:0]   mult_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [CW-1:0]      count_r;
  logic               neg_r;
  logic               sgn_r;
  logic               in_ready_r;
  logic               out_valid_r;
  logic [2*WIDTH-1:0] product_r;
  logic               ovf_r;
  logic               busy_r;

  logic [2*WIDTH-1:0] pp_s;
  logic [2*WIDTH-1:0] acc_nxt_s;
  logic [2*WIDTH-1:0] prod_s;
  logic               last_s;

  // Magnitude of an operand; -2^(WIDTH-1) maps to 2^(WIDTH-1), which still fits unsigned.
  function automatic logic [WIDTH-1:0] abs_f(input logic [WIDTH-1:0] v, input logic s);
    if (s && v[WIDTH-1]) begin
      abs_f = -v;
    end else begin
      abs_f = v;
    end
  endfunction

  function automatic logic ovf_f(input logic [2*WIDTH-1:0] p, input logic s);
    logic [WIDTH:0] hi_s;
    hi_s = p[2*WIDTH-1:WIDTH-1];
    if (s) begin
      ovf_f = (hi_s != '0) && (hi_s != '1);
    end else begin
      ovf_f = (p[2*WIDTH-1:WIDTH] != '0);
    end
  endfunction

  // Partial product for the current digit and the post-step result/exit decision.
  always_comb begin
    pp_s = '0;
    if (mult_r[BPC-1:0] != '0) begin
      pp_s = ((2*WIDTH)'(mcand_r) * (2*WIDTH)'(mult_r[BPC-1:0])) << (32'(count_r) * BPC);
    end else begin
      pp_s = '0;
    end
    acc_nxt_s = acc_r + pp_s;
    if (neg_r) begin
      prod_s = -acc_nxt_s;
    end else begin
      prod_s = acc_nxt_s;
    end
`ifdef SEQ_MULT_EARLY_TERM_EN
    last_s = (count_r == CW'(N - 1)) || ((mult_r >> BPC) == '0);
`else
    last_s = (count_r == CW'(N - 1));
`endif
  end

  // Control FSM, datapath registers and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      mcand_r     <= '0;
      mult_r      <= '0;
      acc_r       <= '0;
      count_r     <= '0;
      neg_r       <= 1'b0;
      sgn_r       <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      product_r   <= '0;
      ovf_r       <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            state_r    <= ST_CALC;
            mcand_r    <= abs_f(a, in_signed);
            mult_r     <= abs_f(b, in_signed);
            neg_r      <= in_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            sgn_r      <= in_signed;
            acc_r      <= '0;
            count_r    <= '0;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
          end
        end
        ST_CALC: begin
          acc_r   <= acc_nxt_s;
          mult_r  <= mult_r >> BPC;
          count_r <= count_r + CW'(1);
          if (last_s) begin
            state_r     <= ST_DONE;
            product_r   <= prod_s;
            ovf_r       <= ovf_f(prod_s, sgn_r);
            out_valid_r <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign product   = product_r;
  assign ovf       = ovf_r;
  assign busy      = busy_r;

endmodule
